mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Execute-stage multiply/divide unit with HI/LO registers. Sits directly downstream of the
//   E-stage operand forwarding muxes: consumes forwarded rs/rt values and runs MULT/MULTU/DIV/DIVU
//   as multi-cycle ops. Handles MTHI/MTLO as single-cycle writes and supplies MFHI/MFLO data as md_hi_lo.
//   Exposes start/busy to the hazard unit so later MD instructions stall in D.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles after a MULT/MULTU issue
//   DIV_CYCLES   10  busy cycles after a DIV/DIVU issue
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   md_op      in   3   E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 rsvd(=NONE)
//   A          in   32  forwarded rs operand (MFALUa)
//   B          in   32  forwarded rt operand
//   rd_sel     in   1   MF read select: 0 LO, 1 HI
//   start      out  1   comb: md_op in {1..4} and unit idle (issue accepted this cycle)
//   busy       out  1   registered: multi-cycle op in flight
//   hi         out  32  HI register
//   lo         out  32  LO register
//   md_hi_lo   out  32  comb: rd_sel ? hi : lo (feeds E->M pipeline register)
// BEHAVIOUR
//   - Reset (sync, high): hi=0, lo=0, busy=0, counter=0, pending results=0, state=IDLE.
//     Reset mid-operation aborts the op; HI/LO not updated.
//   - States: IDLE (busy=0) / RUN (busy=1). 5-bit down-counter cnt.
//   - IDLE, md_op in 1..4: start=1; capture result in pend_hi/pend_lo at this edge;
//     cnt<=N (MULT_CYCLES or DIV_CYCLES); state->RUN.
//   - RUN: cnt decrements each cycle; when cnt==1: hi<=pend_hi, lo<=pend_lo, state->IDLE.
//     Timing: issue in cycle 0 -> busy high cycles 1..N -> new HI/LO and busy=0 visible in cycle N+1.
//   - md_op in 1..6 while busy is ignored (start=0, no state change); hazard unit guarantees
//     none arrive. md_op 0/7 no effect.
//   - MTHI (5): IDLE only; hi<=A at edge. MTLO (6): IDLE only; lo<=A at edge.
//   - MULT: {hi,lo} = $signed(A)*$signed(B), 64-bit. MULTU: unsigned 64-bit product.
//   - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend (A).
//     DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (no trap).
//   - DIVU: lo = A/B, hi = A%B, unsigned.
//   - Divide by zero (B==0, DIV or DIVU): op runs full DIV_CYCLES with busy asserted;
//     HI/LO keep previous values at completion.
//   - md_hi_lo reflects the registered hi/lo only; no internal bypass of pending results
//     (MF during busy is stalled upstream).
//   - Back-to-back: an MD op presented in cycle N+1 (busy=0) is accepted in that cycle.
// TESTING
//   1 reset; MTLO A=0x12345678 then MTHI A=0xCAFEBABE -> lo=0x12345678, hi=0xCAFEBABE;
//     md_hi_lo follows rd_sel.
//   2 MULT A=0xFFFFFFFE(-2) B=3 -> start=1 c0; busy=1 c1..c5; c6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
//   3 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
//   4 DIV A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU A=7 B=0 -> busy 10 cycles, HI/LO unchanged.
//   5 MULT issued, MTHI and DIV presented during busy -> both ignored;
//     final HI/LO = MULT result; DIV presented on cycle busy falls -> accepted (start=1).
//   6 DIV in flight, reset asserted at busy cycle 4 -> next cycle busy=0, hi=lo=0;
//     no later HI/LO write occurs.

Source files
------------

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Ports: clk, reset (sync, active high), md_op[2:0], A[31:0], B[31:0],
//   rd_sel (0 LO / 1 HI); start, busy, hi[31:0], lo[31:0], md_hi_lo[31:0].
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_hi_lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_md;
    logic        b_zero;
    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic [31:0] abs_a, abs_b, div_b;
    logic [31:0] uq, ur;
    logic [31:0] sq, sr;
    logic [31:0] dq, dr;

    // Full-width signed product: sign-extend both operands to 64 bits.
    assign mul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign mul_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes; -2^31 stays 0x80000000 as an unsigned
    // magnitude, so the overflow case folds back to 0x80000000 with no trap.
    assign b_zero = (B == 32'd0);
    assign abs_a  = A[31] ? (~A + 32'd1) : A;
    assign abs_b  = B[31] ? (~B + 32'd1) : B;
    assign div_b  = b_zero ? 32'd1 : abs_b;
    assign uq     = abs_a / div_b;
    assign ur     = abs_a % div_b;
    assign sq     = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
    assign sr     = A[31] ? (~ur + 32'd1) : ur;
    assign dq     = A / (b_zero ? 32'd1 : B);
    assign dr     = A % (b_zero ? 32'd1 : B);

    assign is_md = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                   (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign start = is_md && (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    pend_wr_d = 1'b1;
                    cnt_d     = 5'(DIV_CYCLES);
                    unique case (md_op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = mul_s;
                            cnt_d = 5'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = mul_u;
                            cnt_d = 5'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            pend_hi_d = sr;
                            pend_lo_d = sq;
                            pend_wr_d = !b_zero;
                        end
                        default: begin
                            pend_hi_d = dr;
                            pend_lo_d = dq;
                            pend_wr_d = !b_zero;
                        end
                    endcase
                end else if (md_op == OP_MTHI) begin
                    hi_d = A;
                end else if (md_op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                    // Divide by zero completes without touching HI/LO.
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_hi_lo = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed scenarios plus random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        rd_sel = 1'b0;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_hi_lo;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .rd_sel   (rd_sel),
        .start    (start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_hi_lo (md_hi_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural values.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        longint      x, y;
        logic [63:0] p;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(x * y); {m_hi, m_lo} = p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            3'd3: if (b != 0) begin
                m_lo = 32'(x / y);
                m_hi = 32'(x % y);
            end
            3'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Monitor: pops one expectation per HI/LO-affecting event.
    logic rst_seen = 1'b1;
    logic mt_seen  = 1'b0;
    logic prev_busy = 1'b0;
    int   run_len = 0;

    always @(posedge clk) begin
        rst_seen <= reset;
        mt_seen  <= !reset && !busy && (md_op == 3'd5 || md_op == 3'd6);
    end

    task automatic pop_check(input bit use_len, input int len);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got event expected none");
        end else begin
            e = sb.pop_front();
            chk("sb_hi", hi, e.hi);
            chk("sb_lo", lo, e.lo);
            if (use_len) chk("busy_len", 32'(len), 32'(e.len));
        end
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            run_len = 0;
        end else begin
            if (mt_seen) pop_check(1'b0, 0);
            if (prev_busy && !busy) begin
                pop_check(1'b1, run_len);
                run_len = 0;
            end
            if (busy) run_len++;
        end
        prev_busy = busy;
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit accept);
        exp_t e;
        bit   md;
        @(negedge clk);
        md_op = op;
        A = a;
        B = b;
        #1;
        md = (op >= 3'd1 && op <= 3'd4);
        chk("start", {31'd0, start}, {31'd0, (accept && md)});
        if (accept && op >= 3'd1 && op <= 3'd6) begin
            model_op(op, a, b);
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.len = (op <= 3'd2) ? 5 : (md ? 10 : 0);
            sb.push_back(e);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        md_op = 3'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            idle_cycle();
            n++;
        end while (busy && n < 40);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=1 expected busy=0");
        end
    endtask

    task automatic check_mf();
        rd_sel = 1'b0;
        #1 chk("mf_lo", md_hi_lo, m_lo);
        rd_sel = 1'b1;
        #1 chk("mf_hi", md_hi_lo, m_hi);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          n;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // MTLO / MTHI and read select
        drive(3'd6, 32'h12345678, 32'd0, 1'b1);
        drive(3'd5, 32'hCAFEBABE, 32'd0, 1'b1);
        wait_idle();
        chk("mt_lo", lo, 32'h12345678);
        chk("mt_hi", hi, 32'hCAFEBABE);
        check_mf();

        // MULT -2 * 3
        drive(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_idle();
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        // MULTU max * max
        drive(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        // DIV -7 / 2
        drive(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_idle();
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // DIVU by zero leaves HI/LO alone
        drive(3'd4, 32'd7, 32'd0, 1'b1);
        wait_idle();
        chk("divz_lo", lo, 32'hFFFFFFFD);
        chk("divz_hi", hi, 32'hFFFFFFFF);

        // Signed overflow divide
        drive(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        chk("divov_lo", lo, 32'h80000000);
        chk("divov_hi", hi, 32'h00000000);
        check_mf();

        // Ops during busy ignored; DIV on the cycle busy falls accepted
        drive(3'd1, 32'd1000, 32'hFFFFFFF6, 1'b1);
        idle_cycle();
        drive(3'd5, 32'hDEADBEEF, 32'd0, 1'b0);
        drive(3'd3, 32'd50, 32'd7, 1'b0);
        idle_cycle();
        idle_cycle();
        drive(3'd3, 32'd100, 32'd7, 1'b1);
        wait_idle();
        chk("b2b_lo", lo, 32'd14);
        chk("b2b_hi", hi, 32'd2);

        // Reset in the middle of a DIV
        drive(3'd3, 32'd1234567, 32'd89, 1'b1);
        repeat (4) idle_cycle();
        reset = 1'b1;
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (12) idle_cycle();
        chk("abort_hi_late", hi, 32'd0);
        chk("abort_lo_late", lo, 32'd0);

        // Random ops
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            if ($urandom_range(0, 3) == 0) a = -a;
            drive(op, a, b, 1'b1);
            wait_idle();
            if (i % 8 == 0) check_mf();
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle_cycle();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
